pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//   Parametrised, pipelined ripple-carry adder/subtractor: next generation of the
//   single-bit full adder cell. Splits a WIDTH-bit add into STAGES chunks, one chunk
//   per clock, carry registered between stages. Streams one operation per cycle
//   under valid/ready handshake; datapath building block for the ALU.
// PARAMETERS
//   WIDTH   32  operand/result width in bits; must be >= 2
//   STAGES   4  pipeline stages; 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0
//   CHUNK = WIDTH/STAGES is a derived localparam, not overridable
// PORTS
//   clk        in   1      clock, all state on rising edge
//   rst        in   1      asynchronous reset, active-high
//   in_valid   in   1      operands valid
//   in_ready   out  1      block accepts operands this cycle
//   a          in   WIDTH  operand A
//   b          in   WIDTH  operand B
//   carry_in   in   1      carry into bit 0 (add mode only)
//   op_sub     in   1      0: a+b+carry_in; 1: a-b (a + ~b + 1)
//   out_valid  out  1      result valid
//   out_ready  in   1      downstream accepts result
//   sum        out  WIDTH  result
//   carry_out  out  1      carry out of MSB (sub: 1 = no borrow)
// BEHAVIOUR
//   - Reset (async assert, sync release): all stage valids 0, out_valid 0, sum 0,
//     carry_out 0; in-flight operations discarded, none emerge after release.
//   - Transfer in when in_valid & in_ready; out when out_valid & out_ready.
//   - advance = !out_valid | out_ready; in_ready = advance (combinational).
//     All stage registers (data, carry, valid) load only when advance = 1.
//   - Bubbles: if advance and !in_valid, stage 0 valid loads 0; bubbles flow through.
//   - Latency: exactly STAGES advancing cycles from accept to out_valid. Throughput
//     1 op/cycle with out_ready held 1.
//   - Stage k (0..STAGES-1) adds chunk k of a and b_eff plus carry from stage k-1
//     (stage 0 uses cin_eff); upper chunks of a/b_eff and completed lower sum
//     chunks skew through registers so each op's bits exit together.
//   - b_eff = op_sub ? ~b : b; cin_eff = op_sub ? 1 : carry_in. op_sub captured at
//     accept; carry_in ignored when op_sub = 1.
//   - Results modulo 2^WIDTH; carry_out = bit WIDTH of the full-width sum.
//   - Stall: out_valid=1, out_ready=0 -> sum, carry_out, flags held stable; nothing
//     accepted. Output changes only on handshake or reset.
//   - STAGES=1: single registered add, latency 1.
//   - Simultaneous in and out transfer in same cycle is legal and is the steady state.
// CONFIGURATION
//   ADDER_FLAGS_EN defined: extra outputs, registered with sum, reset 0:
//     overflow out 1  signed overflow (MSB carry-in XOR carry_out)
//     zero     out 1  sum == 0
//     negative out 1  sum[WIDTH-1]
//   ADDER_FLAGS_EN undefined: these ports and their logic do not exist.
// TESTING (WIDTH=8, STAGES=2 unless stated)
//   1 a=FF b=01 cin=0 add, out_ready=1 -> 2 cycles later sum=00 carry_out=1
//   2 a=05 b=07 op_sub=1 cin=1 -> sum=FE carry_out=0; a=07 b=05 -> sum=02 cout=1
//   3 stream 16 random ops back-to-back, out_ready=1 -> in_ready stays 1, results
//     in order, 1 per cycle, match a+b+cin mod 256 golden model
//   4 out_ready=0, drive 4 ops -> exactly 2 accepted before in_ready=0; sum held;
//     release -> both results in order, then remaining ops accepted
//   5 rst pulse with 2 ops in flight -> outputs 0 immediately, out_valid never
//     rises for discarded ops; next op after release completes normally
//   6 ADDER_FLAGS_EN, a=7F b=01 add -> sum=80 overflow=1 negative=1 zero=0;
//     a=01 b=01 sub -> sum=00 zero=1 carry_out=1; repeat 1 with WIDTH=32 STAGES=4

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry registered between stages.
// Optional status flags (overflow, zero, negative) are built when ADDER_FLAGS_EN is defined.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef ADDER_FLAGS_EN
    ,
    output logic             overflow,
    output logic             zero,
    output logic             negative
`endif
);

    localparam int CHUNK = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    logic             advance;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];
    logic             v_q [STAGES];
    logic             v_d [STAGES];

    // Adds slice k of x and y plus cin, writes it into s; returns {carry, updated s}.
    function automatic logic [WIDTH:0] add_chunk(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y,
        input logic [WIDTH-1:0] s,
        input logic             cin,
        input int               k
    );
        logic [CHUNK:0]   part;
        logic [WIDTH-1:0] r;
        part = {1'b0, x[k*CHUNK +: CHUNK]} + {1'b0, y[k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, cin};
        r = s;
        r[k*CHUNK +: CHUNK] = part[CHUNK-1:0];
        return {part[CHUNK], r};
    endfunction

    assign advance   = !v_q[LAST] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[LAST];
    assign sum       = s_q[LAST];
    assign carry_out = c_q[LAST];

    assign b_eff   = op_sub ? ~b : b;
    assign cin_eff = op_sub ? 1'b1 : carry_in;

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
            s_d[k] = s_q[k];
            c_d[k] = c_q[k];
            v_d[k] = v_q[k];
        end
        if (advance) begin
            a_d[0] = a;
            b_d[0] = b_eff;
            {c_d[0], s_d[0]} = add_chunk(a, b_eff, '0, cin_eff, 0);
            v_d[0] = in_valid;
            // Upper operand slices and finished low sum slices ride along so an op exits intact.
            for (int k = 1; k < STAGES; k++) begin
                a_d[k] = a_q[k-1];
                b_d[k] = b_q[k-1];
                {c_d[k], s_d[k]} = add_chunk(a_q[k-1], b_q[k-1], s_q[k-1], c_q[k-1], k);
                v_d[k] = v_q[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                s_q[k] <= s_d[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
        end
    end

`ifdef ADDER_FLAGS_EN
    logic overflow_d, zero_d, negative_d;
    logic overflow_q, zero_q, negative_q;

    // Carry into the MSB is recovered from the MSB operand bits and the MSB sum bit.
    always_comb begin
        overflow_d = a_d[LAST][WIDTH-1] ^ b_d[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
        zero_d     = (s_d[LAST] == '0);
        negative_d = s_d[LAST][WIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
        end
    end

    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign negative = negative_q;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: 8-bit/2-stage instance with a queue-based model, plus a 32-bit/4-stage instance.
module tb_pipelined_adder;
    localparam int W   = 8;
    localparam int S   = 2;
    localparam int W32 = 32;
    localparam int S32 = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, carry_in, op_sub, out_valid, out_ready, carry_out;
    logic [W-1:0] a, b, sum;
`ifdef ADDER_FLAGS_EN
    logic         overflow, zero, negative;
    logic         ov32, z32, n32;
`endif

    logic           in_valid32, in_ready32, carry_in32, op_sub32, out_valid32, out_ready32, carry_out32;
    logic [W32-1:0] a32, b32, sum32;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .carry_out(carry_out)
`ifdef ADDER_FLAGS_EN
        , .overflow(overflow), .zero(zero), .negative(negative)
`endif
    );

    pipelined_adder #(.WIDTH(W32), .STAGES(S32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
        .a(a32), .b(b32), .carry_in(carry_in32), .op_sub(op_sub32),
        .out_valid(out_valid32), .out_ready(out_ready32), .sum(sum32), .carry_out(carry_out32)
`ifdef ADDER_FLAGS_EN
        , .overflow(ov32), .zero(z32), .negative(n32)
`endif
    );

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] s;
        logic        c;
        logic        ov;
        logic        z;
        logic        n;
    } exp_t;

    // Plain integer arithmetic: subtraction as a-b with "no borrow" carry, overflow as signed range escape.
    function automatic exp_t model(input int w, input logic [31:0] x, input logic [31:0] y,
                                   input logic cin, input logic sub);
        exp_t    e;
        longint  m, ux, uy, r, sx, sy, sr;
        m  = longint'(1) << w;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= m / 2) ? ux - m : ux;
        sy = (uy >= m / 2) ? uy - m : uy;
        if (sub) begin
            r    = (ux - uy + m) % m;
            e.c  = (ux >= uy);
            sr   = sx - sy;
        end else begin
            r    = ux + uy + longint'(cin);
            e.c  = (r >= m);
            r    = r % m;
            sr   = sx + sy + longint'(cin);
        end
        e.s  = r[31:0];
        e.z  = (r == 0);
        e.n  = (r >= m / 2);
        e.ov = (sr < -(m / 2)) || (sr >= m / 2);
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic cin, input logic sub);
        a = x; b = y; carry_in = cin; op_sub = sub; in_valid = 1'b1;
    endtask

    exp_t         q[$];
    exp_t         mon_e;
    logic         held_v;
    logic [W-1:0] held_s;
    logic         held_c;

    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            held_v = 1'b0;
        end else begin
            chk("in_ready_rule", 64'(in_ready), 64'(!out_valid || out_ready));
            if (held_v) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_sum", 64'(sum), 64'(held_s));
                chk("stall_cout", 64'(carry_out), 64'(held_c));
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output actual sum=%0h required no result", sum);
                end else begin
                    mon_e = q.pop_front();
                    chk("sum", 64'(sum), 64'(mon_e.s[W-1:0]));
                    chk("carry_out", 64'(carry_out), 64'(mon_e.c));
`ifdef ADDER_FLAGS_EN
                    chk("overflow", 64'(overflow), 64'(mon_e.ov));
                    chk("zero", 64'(zero), 64'(mon_e.z));
                    chk("negative", 64'(negative), 64'(mon_e.n));
`endif
                end
            end
            if (in_valid && in_ready)
                q.push_back(model(W, 32'(a), 32'(b), carry_in, op_sub));
            held_v = out_valid && !out_ready;
            held_s = sum;
            held_c = carry_out;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    logic [W-1:0] t4a [4];
    logic [W-1:0] t4b [4];
    logic         t4c [4];
    logic         t4s [4];
    int           acc;
    logic         took;
    exp_t         e0;
    exp_t         exp32 [8];

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; op_sub = 1'b0; out_ready = 1'b1;
        in_valid32 = 1'b0; a32 = '0; b32 = '0; carry_in32 = 1'b0; op_sub32 = 1'b0; out_ready32 = 1'b1;
        #1 rst = 1'b1;
        #11;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_sum", 64'(sum), 64'(0));
        chk("rst_cout", 64'(carry_out), 64'(0));
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid32", 64'(out_valid32), 64'(0));
        tick();
        rst = 1'b0;
        tick();

        // FF + 01: wraps to 00 with carry out, two cycles after accept
        set_op(8'hFF, 8'h01, 1'b0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("t1_not_yet", 64'(out_valid), 64'(0));
        tick();
        chk("t1_valid", 64'(out_valid), 64'(1));
        chk("t1_sum", 64'(sum), 64'(8'h00));
        chk("t1_cout", 64'(carry_out), 64'(1));
        tick();

        // Subtraction ignores carry_in; carry_out means no borrow
        set_op(8'h05, 8'h07, 1'b1, 1'b1);
        tick();
        set_op(8'h07, 8'h05, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t2a_sum", 64'(sum), 64'(8'hFE));
        chk("t2a_cout", 64'(carry_out), 64'(0));
        tick();
        chk("t2b_valid", 64'(out_valid), 64'(1));
        chk("t2b_sum", 64'(sum), 64'(8'h02));
        chk("t2b_cout", 64'(carry_out), 64'(1));
        tick();

        // Back-to-back stream at full rate
        for (int i = 0; i < 16; i++) begin
            set_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            chk("t3_in_ready", 64'(in_ready), 64'(1));
            tick();
            if (i >= 1) chk("t3_out_valid", 64'(out_valid), 64'(1));
        end
        in_valid = 1'b0;
        tick();
        chk("t3_last_valid", 64'(out_valid), 64'(1));
        tick();
        tick();

        // Backpressure: only the pipeline depth is accepted while the output is stalled
        for (int i = 0; i < 4; i++) begin
            t4a[i] = 8'($urandom); t4b[i] = 8'($urandom);
            t4c[i] = 1'($urandom); t4s[i] = 1'($urandom);
        end
        e0 = model(W, 32'(t4a[0]), 32'(t4b[0]), t4c[0], t4s[0]);
        acc = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            set_op(t4a[acc], t4b[acc], t4c[acc], t4s[acc]);
            took = in_ready;
            tick();
            if (took) acc++;
        end
        chk("t4_accepted", 64'(acc), 64'(2));
        chk("t4_in_ready", 64'(in_ready), 64'(0));
        chk("t4_held_sum", 64'(sum), 64'(e0.s[W-1:0]));
        chk("t4_held_cout", 64'(carry_out), 64'(e0.c));
        out_ready = 1'b1;
        for (int c = 0; c < 20 && acc < 4; c++) begin
            set_op(t4a[acc], t4b[acc], t4c[acc], t4s[acc]);
            took = in_ready;
            tick();
            if (took) acc++;
        end
        in_valid = 1'b0;
        chk("t4_all_accepted", 64'(acc), 64'(4));
        repeat (4) tick();

        // Reset with two ops in flight
        set_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        tick();
        set_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
        tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t5_out_valid", 64'(out_valid), 64'(0));
        chk("t5_sum", 64'(sum), 64'(0));
        chk("t5_cout", 64'(carry_out), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t5_no_ghost", 64'(out_valid), 64'(0));
        end
        set_op(8'h12, 8'h34, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tick();
        chk("t5_after_valid", 64'(out_valid), 64'(1));
        chk("t5_after_sum", 64'(sum), 64'(8'h47));
        tick();

`ifdef ADDER_FLAGS_EN
        set_op(8'h7F, 8'h01, 1'b0, 1'b0);
        tick();
        set_op(8'h01, 8'h01, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        chk("t6a_sum", 64'(sum), 64'(8'h80));
        chk("t6a_overflow", 64'(overflow), 64'(1));
        chk("t6a_negative", 64'(negative), 64'(1));
        chk("t6a_zero", 64'(zero), 64'(0));
        tick();
        chk("t6b_sum", 64'(sum), 64'(8'h00));
        chk("t6b_zero", 64'(zero), 64'(1));
        chk("t6b_cout", 64'(carry_out), 64'(1));
        chk("t6b_overflow", 64'(overflow), 64'(0));
        tick();
`endif

        // 32-bit, 4-stage instance: latency 4, then a random stream
        a32 = 32'hFFFF_FFFF; b32 = 32'h1; carry_in32 = 1'b0; op_sub32 = 1'b0; in_valid32 = 1'b1;
        tick();
        in_valid32 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("w32_not_yet", 64'(out_valid32), 64'(0));
            tick();
        end
        chk("w32_valid", 64'(out_valid32), 64'(1));
        chk("w32_sum", 64'(sum32), 64'(0));
        chk("w32_cout", 64'(carry_out32), 64'(1));
        tick();
        for (int i = 0; i < 11; i++) begin
            if (i < 8) begin
                a32 = $urandom; b32 = $urandom; carry_in32 = 1'($urandom); op_sub32 = 1'($urandom);
                in_valid32 = 1'b1;
                exp32[i] = model(W32, a32, b32, carry_in32, op_sub32);
            end else begin
                in_valid32 = 1'b0;
            end
            tick();
            if (i >= 3) begin
                chk("w32_stream_valid", 64'(out_valid32), 64'(1));
                chk("w32_stream_sum", 64'(sum32), 64'(exp32[i-3].s));
                chk("w32_stream_cout", 64'(carry_out32), 64'(exp32[i-3].c));
            end
        end
        in_valid32 = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
